// File: rtl/rv32i_test_pkg.sv
// Shared types and constants for the rv32i compliance-test sequencer.
package rv32i_test_pkg;

    typedef enum logic [2:0] {IDLE, INIT, LOAD, RESET, RUN, REPORT} state_e;
    typedef enum logic [1:0] {RES_NONE, RES_PASS, RES_FAIL, RES_TIMEOUT} result_e;

    localparam logic [6:0]  OPC_OP_IMM    = 7'h13;
    localparam logic [31:0] GP_PASS       = 32'h1;
    localparam int          NUM_INIT_REGS = 31;

    // addi rd, x0, 0
    function automatic logic [31:0] addi_zero(input logic [4:0] rd);
        return {20'h0, rd, OPC_OP_IMM};
    endfunction

endpackage

// File: rtl/rv32i_test_ctrl.sv
// Sequencer for one rv32i compliance run: register-init writes, image load,
// core reset pulse, ecall watch and pass/fail/timeout report.
module rv32i_test_ctrl
    import rv32i_test_pkg::*;
#(
    parameter int MEM_AW         = 10,
    parameter int RST_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              load_req,
    input  logic              load_ack,
    output logic              core_rst_n,
    input  logic              core_is_ecall,
    input  logic [31:0]       core_gp,
    output logic              done,
    output logic [1:0]        result,
    output logic [CNT_W-1:0]  run_cycles
);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    result_e             r_result;
    logic [CNT_W-1:0]    r_run_cycles;
    logic                r_busy;
    logic                r_mem_we;
    logic [MEM_AW-1:0]   r_mem_waddr;
    logic [31:0]         r_mem_wdata;
    logic                r_load_req;
    logic                r_core_rst_n;
    logic                r_done;

    state_e              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    result_e             w_result_nxt;
    logic [CNT_W-1:0]    w_run_cycles_nxt;
    logic                w_mem_we_nxt;
    logic [MEM_AW-1:0]   w_mem_waddr_nxt;
    logic [31:0]         w_mem_wdata_nxt;

    // One counter serves as INIT index (1..31), RESET hold and RUN cycle count.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + CNT_W'(1);
        w_result_nxt     = r_result;
        w_run_cycles_nxt = r_run_cycles;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt      = INIT;
                    w_cnt_nxt        = CNT_W'(1);
                    w_result_nxt     = RES_NONE;
                    w_run_cycles_nxt = '0;
                end
            end
            INIT: begin
                if (r_cnt == CNT_W'(NUM_INIT_REGS)) begin
                    w_state_nxt = LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            LOAD: begin
                w_cnt_nxt = '0;
                if (load_ack) w_state_nxt = RESET;
            end
            RESET: begin
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (core_is_ecall) begin
                    w_result_nxt     = (core_gp == GP_PASS) ? RES_PASS : RES_FAIL;
                    w_run_cycles_nxt = r_cnt;
                    w_state_nxt      = REPORT;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_result_nxt     = RES_TIMEOUT;
                    w_run_cycles_nxt = CNT_W'(TIMEOUT_CYCLES);
                    w_state_nxt      = REPORT;
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        w_mem_we_nxt    = (w_state_nxt == INIT);
        w_mem_waddr_nxt = w_mem_we_nxt ? (w_cnt_nxt[MEM_AW-1:0] - MEM_AW'(1)) : '0;
        w_mem_wdata_nxt = w_mem_we_nxt ? addi_zero(w_cnt_nxt[4:0]) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_result     <= RES_NONE;
            r_run_cycles <= '0;
            r_busy       <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_load_req   <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_result     <= w_result_nxt;
            r_run_cycles <= w_run_cycles_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_mem_we     <= w_mem_we_nxt;
            r_mem_waddr  <= w_mem_waddr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_load_req   <= (w_state_nxt == LOAD);
            r_core_rst_n <= (w_state_nxt == RUN);
            r_done       <= (w_state_nxt == REPORT);
        end
    end

    assign busy       = r_busy;
    assign mem_we     = r_mem_we;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;
    assign load_req   = r_load_req;
    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign result     = r_result;
    assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_rv32i_test_ctrl.sv
// Directed bench for rv32i_test_ctrl: init writes, load handshake, reset hold,
// pass/fail/timeout/tie, ignored starts and mid-run reset.
module tb_rv32i_test_ctrl;

    localparam int MEM_AW = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              load_req;
    logic              load_ack = 1'b0;
    logic              core_rst_n;
    logic              core_is_ecall = 1'b0;
    logic [31:0]       core_gp = 32'h0;
    logic              done;
    logic [1:0]        result;
    logic [CNT_W-1:0]  run_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    rv32i_test_ctrl #(
        .MEM_AW(MEM_AW), .RST_CYCLES(10), .TIMEOUT_CYCLES(5000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .load_req(load_req), .load_ack(load_ack), .core_rst_n(core_rst_n),
        .core_is_ecall(core_is_ecall), .core_gp(core_gp), .done(done),
        .result(result), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_mem_waddr"}, 32'(mem_waddr), 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_load_req"}, 32'(load_req), 32'h0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_run_cycles"}, 32'(run_cycles), 32'h0);
    endtask

    // Pulse start, answer load_req, return at the negedge of RUN cycle 0.
    task automatic start_to_run(input string tag);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start    = 1'b0;
            load_ack = 1'b0;
            if (core_rst_n) begin
                ok = 1'b1;
                break;
            end
            if (load_req) load_ack = 1'b1;
        end
        check({tag, "_reach_run"}, 32'(ok), 32'h1);
    endtask

    initial begin
        int  lowcnt;
        bit  early;

        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_core_rst_n", 32'(core_rst_n), 32'h0);

        // Init writes, with a stray start and an early load_ack that must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("init_busy", 32'(busy), 32'h1);
        for (int j = 1; j <= 31; j++) begin
            check("init_we", 32'(mem_we), 32'h1);
            check("init_addr", 32'(mem_waddr), 32'(j - 1));
            check("init_data", mem_wdata, (32'(j) << 7) | 32'h13);
            if (j == 1)  check("init_data_x1", mem_wdata, 32'h0000_0093);
            if (j == 5)  check("init_data_x5", mem_wdata, 32'h0000_0293);
            if (j == 31) check("init_data_x31", mem_wdata, 32'h0000_0F93);
            start    = (j == 10);
            load_ack = (j == 20);
            @(negedge clk);
        end
        start    = 1'b0;
        load_ack = 1'b0;

        // Load handshake: ack in the third LOAD cycle
        check("load_we", 32'(mem_we), 32'h0);
        check("load_req1", 32'(load_req), 32'h1);
        @(negedge clk);
        check("load_req2", 32'(load_req), 32'h1);
        @(negedge clk);
        check("load_req3", 32'(load_req), 32'h1);
        check("load_core_rst_n", 32'(core_rst_n), 32'h0);
        load_ack = 1'b1;
        @(negedge clk);
        load_ack = 1'b0;
        check("load_req_drop", 32'(load_req), 32'h0);

        // Reset hold length
        lowcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (core_rst_n) break;
            lowcnt++;
            @(negedge clk);
        end
        check("rst_hold_len", 32'(lowcnt), 32'd10);
        check("run_core_rst_n", 32'(core_rst_n), 32'h1);

        // Pass at RUN cycle 200, stray start at cycle 50
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (149) @(negedge clk);
        check("pass_busy_run", 32'(busy), 32'h1);
        check("pass_no_done_yet", 32'(done), 32'h0);
        core_gp       = 32'h1;
        core_is_ecall = 1'b1;
        @(negedge clk);
        core_is_ecall = 1'b0;
        check("pass_done", 32'(done), 32'h1);
        check("pass_result", 32'(result), 32'h1);
        check("pass_cycles", 32'(run_cycles), 32'd200);
        check("pass_core_rst_n", 32'(core_rst_n), 32'h0);
        check("pass_busy_report", 32'(busy), 32'h1);
        @(negedge clk);
        check("pass_done_pulse", 32'(done), 32'h0);
        check("pass_busy_after", 32'(busy), 32'h0);
        check("pass_result_hold", 32'(result), 32'h1);
        check("pass_cycles_hold", 32'(run_cycles), 32'd200);

        // Fail at RUN cycle 0; result cleared during the run
        start_to_run("fail");
        check("fail_result_cleared", 32'(result), 32'h0);
        check("fail_cycles_cleared", 32'(run_cycles), 32'h0);
        core_gp       = 32'h5;
        core_is_ecall = 1'b1;
        @(negedge clk);
        core_is_ecall = 1'b0;
        check("fail_done", 32'(done), 32'h1);
        check("fail_result", 32'(result), 32'h2);
        check("fail_cycles", 32'(run_cycles), 32'd0);

        // Timeout
        start_to_run("tmo");
        early = 1'b0;
        for (int i = 0; i < 4999; i++) begin
            @(negedge clk);
            if (done) early = 1'b1;
        end
        check("tmo_no_early_done", 32'(early), 32'h0);
        @(negedge clk);
        check("tmo_done", 32'(done), 32'h1);
        check("tmo_result", 32'(result), 32'h3);
        check("tmo_cycles", 32'(run_cycles), 32'd5000);

        // Ecall and timeout in the same cycle, then start in REPORT
        start_to_run("tie");
        repeat (4999) @(negedge clk);
        core_gp       = 32'h1;
        core_is_ecall = 1'b1;
        @(negedge clk);
        core_is_ecall = 1'b0;
        check("tie_done", 32'(done), 32'h1);
        check("tie_result", 32'(result), 32'h1);
        check("tie_cycles", 32'(run_cycles), 32'd4999);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("report_start_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("report_start_busy2", 32'(busy), 32'h0);
        check("report_start_we", 32'(mem_we), 32'h0);

        // rst_n asserted mid-run
        start_to_run("midrst");
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        core_is_ecall = 1'b1;
        core_gp       = 32'h1;
        early = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) early = 1'b1;
        end
        check("midrst_no_done", 32'(early), 32'h0);
        core_is_ecall = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'h0);

        // Clean run after the interrupted one
        start_to_run("again");
        check("again_result_cleared", 32'(result), 32'h0);
        repeat (3) @(negedge clk);
        core_gp       = 32'h1;
        core_is_ecall = 1'b1;
        @(negedge clk);
        core_is_ecall = 1'b0;
        check("again_done", 32'(done), 32'h1);
        check("again_result", 32'(result), 32'h1);
        check("again_cycles", 32'(run_cycles), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
